// File: rtl/mux7seg_scan.sv
// ---------------------------------------------------------------------------
// mux7seg_scan
//
// Scans a multiplexed common-anode 7-segment bank of NUM_DIGITS digits.
// The CPU writes a shadow buffer with a one-cycle 'load' strobe. The shadow
// is copied into the active (displayed) buffer only at a frame boundary, so
// a frame never shows a mix of old and new data.
//
// Features: per-digit blanking, per-digit decimal points, leading-zero
// suppression and 16-level PWM brightness.
//
// Optional feature macro: SEG7_BLINK_EN
//   When defined, a frame counter makes digits flagged in blink_in flash.
//   Each dark or lit phase lasts 2^BLINK_LOG2 frames.
//   When undefined, blink_in is ignored.
//
// Parameters:
//   NUM_DIGITS  number of digits (1..16)
//   DIV_LOG2    log2 of clock cycles per digit slot (>= 5)
//   BLINK_LOG2  blink half-period in frames, as a power of two
//
// Ports:
//   CLK100MHZ    in   system clock
//   resetn       in   asynchronous active-low reset
//   load         in   strobe; captures digit_in/dp_in/blank_in/blink_in
//   digit_in     in   hex nibbles, digit k = [4k+3:4k]
//   dp_in        in   1 = decimal point lit for digit k
//   blank_in     in   1 = digit k forced dark
//   blink_in     in   1 = digit k blinks (SEG7_BLINK_EN only)
//   lzs_en       in   leading-zero suppression enable (live)
//   duty         in   brightness, 15 = full on, 0 = 1/16 on
//   pending      out  shadow holds data not yet displayed
//   frame_start  out  one-cycle pulse when scanning wraps to digit 0
//   AN           out  active-low anodes
//   A2G          out  active-low segments, bit 6 = g ... bit 0 = a
//   DP           out  active-low decimal point
// ---------------------------------------------------------------------------
module mux7seg_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_LOG2   = 17,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                    CLK100MHZ,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lzs_en,
  input  logic [3:0]              duty,
  output logic                    pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              A2G,
  output logic                    DP
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_LOG2-1:0]     prescaler;
  logic [IDX_W-1:0]        scan_idx;
  logic                    slot_tick;
  logic                    frame_wrap;
  logic [3:0]              phase;

  logic [4*NUM_DIGITS-1:0] shadow_digit;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [4*NUM_DIGITS-1:0] active_digit;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [NUM_DIGITS-1:0]   active_blank;

  logic [NUM_DIGITS-1:0]   suppressed;
  logic [NUM_DIGITS-1:0]   blink_mask;

  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              a2g_next;
  logic                    dp_next;

  // A slot ends on the cycle the prescaler is about to wrap to zero.
  // The frame ends on the slot tick that also returns the index to digit 0.
  assign slot_tick  = &prescaler;
  assign frame_wrap = slot_tick && (scan_idx == LAST_IDX);

  // The top four prescaler bits form a sawtooth across each slot.
  // Comparing this sawtooth against duty gives the PWM brightness.
  assign phase = prescaler[DIV_LOG2-1 -: 4];

  // Standard active-low hex glyphs (bit 6 = g ... bit 0 = a).
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_glyph = 7'h40;
      4'h1:    hex_glyph = 7'h79;
      4'h2:    hex_glyph = 7'h24;
      4'h3:    hex_glyph = 7'h30;
      4'h4:    hex_glyph = 7'h19;
      4'h5:    hex_glyph = 7'h12;
      4'h6:    hex_glyph = 7'h02;
      4'h7:    hex_glyph = 7'h78;
      4'h8:    hex_glyph = 7'h00;
      4'h9:    hex_glyph = 7'h10;
      4'hA:    hex_glyph = 7'h08;
      4'hB:    hex_glyph = 7'h03;
      4'hC:    hex_glyph = 7'h46;
      4'hD:    hex_glyph = 7'h21;
      4'hE:    hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Free-running slot prescaler and digit scan index.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      prescaler <= '0;
      scan_idx  <= '0;
    end else begin
      prescaler <= prescaler + DIV_LOG2'(1);
      if (slot_tick) begin
        scan_idx <= frame_wrap ? '0 : scan_idx + IDX_W'(1);
      end
    end
  end

  // Double buffer.
  // The shadow is copied into the active buffer only on a frame wrap.
  // A load on the wrap cycle still applies the previous shadow.
  // The new data captured on that cycle stays pending until the next frame.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      shadow_digit <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      active_digit <= '0;
      active_dp    <= '0;
      active_blank <= '0;
      pending      <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap && pending) begin
        active_digit <= shadow_digit;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      if (load) begin
        shadow_digit <= digit_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
        pending      <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BC_W = BLINK_LOG2 + 1;

  logic [NUM_DIGITS-1:0] shadow_blink;
  logic [NUM_DIGITS-1:0] active_blink;
  logic [BC_W-1:0]       blink_cnt;

  // The blink flags are double-buffered like the other digit attributes.
  // The frame counter's MSB selects the dark half of the blink period.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      shadow_blink <= '0;
      active_blink <= '0;
      blink_cnt    <= '0;
    end else begin
      if (frame_wrap) begin
        blink_cnt <= blink_cnt + BC_W'(1);
        if (pending) begin
          active_blink <= shadow_blink;
        end
      end
      if (load) begin
        shadow_blink <= blink_in;
      end
    end
  end

  assign blink_mask = active_blink & {NUM_DIGITS{blink_cnt[BLINK_LOG2]}};
`else
  logic unused_blink;

  assign blink_mask   = '0;
  assign unused_blink = ^{blink_in, {(BLINK_LOG2 + 1){1'b0}}};
`endif

  // Leading-zero suppression.
  // A digit is suppressed when it and every digit above it hold zero.
  // Blanked digits are dark regardless, so they need no special case here.
  // Digit 0 is never suppressed, so an all-zero value still shows "0".
  always_comb begin
    logic all_zero;
    suppressed = '0;
    all_zero   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero && (active_digit[4*k +: 4] == 4'h0);
      suppressed[k] = lzs_en && all_zero;
    end
  end

  // Decode the current slot.
  // At most one anode can go low, because only the digit matching the
  // scan index is ever considered.
  always_comb begin
    an_next  = '1;
    a2g_next = 7'h7F;
    dp_next  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        if (!(active_blank[k] || suppressed[k] || blink_mask[k] ||
              (phase > duty))) begin
          an_next[k] = 1'b0;
          a2g_next   = hex_glyph(active_digit[4*k +: 4]);
          dp_next    = ~active_dp[k];
        end
      end
    end
  end

  // Register the pin drivers so they cannot glitch between slots.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      AN  <= '1;
      A2G <= 7'h7F;
      DP  <= 1'b1;
    end else begin
      AN  <= an_next;
      A2G <= a2g_next;
      DP  <= dp_next;
    end
  end

endmodule

// File: tb/tb_mux7seg_scan.sv
// ---------------------------------------------------------------------------
// tb_mux7seg_scan
//
// Self-checking bench for mux7seg_scan with NUM_DIGITS=8 and DIV_LOG2=6.
//
// The reference model derives the expected pin state from the elapsed cycle
// count:
//   slot  = count / 64
//   digit = slot mod 8
//   phase = position within the slot / 4
// The model also tracks a shadow/active copy of the loaded data.
//
// On every clock the model queues the expected outputs. A monitor on the
// falling edge pops each entry and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_mux7seg_scan;

  localparam int ND    = 8;
  localparam int DL    = 6;
  localparam int BL    = 1;
  localparam int SLOT  = 1 << DL;
  localparam int FRAME = SLOT * ND;

  logic          CLK100MHZ = 1'b0;
  logic          resetn    = 1'b1;
  logic          load      = 1'b0;
  logic [31:0]   digit_in  = '0;
  logic [7:0]    dp_in     = '0;
  logic [7:0]    blank_in  = '0;
  logic [7:0]    blink_in  = '0;
  logic          lzs_en    = 1'b0;
  logic [3:0]    duty      = 4'hF;
  logic          pending;
  logic          frame_start;
  logic [7:0]    AN;
  logic [6:0]    A2G;
  logic          DP;

  mux7seg_scan #(
    .NUM_DIGITS (ND),
    .DIV_LOG2   (DL),
    .BLINK_LOG2 (BL)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .resetn      (resetn),
    .load        (load),
    .digit_in    (digit_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .blink_in    (blink_in),
    .lzs_en      (lzs_en),
    .duty        (duty),
    .pending     (pending),
    .frame_start (frame_start),
    .AN          (AN),
    .A2G         (A2G),
    .DP          (DP)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] a2g;
    logic       dp;
    logic       pend;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state (count of clock edges since reset release).
  int          n = 0;
  int          m_frames = 0;
  logic [31:0] m_act_dig, m_sh_dig;
  logic [7:0]  m_act_dp, m_sh_dp, m_act_blank, m_sh_blank;
  logic [7:0]  m_act_blink, m_sh_blink;
  logic        m_pend;

  task automatic checkOutput(input string name, input exp_t act,
                             input exp_t want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got AN=%h A2G=%h DP=%b pend=%b fs=%b, expected AN=%h A2G=%h DP=%b pend=%b fs=%b",
               name, $time, act.an, act.a2g, act.dp, act.pend, act.fs,
               want.an, want.a2g, want.dp, want.pend, want.fs);
    end
  endtask

  // Reference model: predicts the outputs the DUT registers at this edge.
  initial begin : model
    int         psc;
    int         idx;
    logic       wrap;
    logic       dark;
    logic [3:0] nib;
    exp_t       e;
    forever begin
      @(posedge CLK100MHZ);
      if (!resetn) begin
        n           = 0;
        m_frames    = 0;
        m_act_dig   = '0;
        m_sh_dig    = '0;
        m_act_dp    = '0;
        m_sh_dp     = '0;
        m_act_blank = '0;
        m_sh_blank  = '0;
        m_act_blink = '0;
        m_sh_blink  = '0;
        m_pend      = 1'b0;
        exp_q.delete();
      end else begin
        psc  = n % SLOT;
        idx  = (n / SLOT) % ND;
        wrap = (psc == SLOT - 1) && (idx == ND - 1);
        nib  = 4'((m_act_dig >> (4 * idx)) & 32'hF);
        dark = m_act_blank[idx] ||
               (lzs_en && idx > 0 && (m_act_dig >> (4 * idx)) == 0) ||
               ((psc >> (DL - 4)) > int'(duty));
`ifdef SEG7_BLINK_EN
        dark = dark || (m_act_blink[idx] && ((m_frames >> BL) % 2 == 1));
`endif
        e.an   = dark ? 8'hFF : ~(8'(1) << idx);
        e.a2g  = dark ? 7'h7F : glyph_tab[nib];
        e.dp   = dark ? 1'b1 : ~m_act_dp[idx];
        e.pend = load ? 1'b1 : (wrap ? 1'b0 : m_pend);
        e.fs   = wrap;
        exp_q.push_back(e);

        if (wrap) begin
          if (m_pend) begin
            m_act_dig   = m_sh_dig;
            m_act_dp    = m_sh_dp;
            m_act_blank = m_sh_blank;
            m_act_blink = m_sh_blink;
          end
          m_frames++;
        end
        if (load) begin
          m_sh_dig   = digit_in;
          m_sh_dp    = dp_in;
          m_sh_blank = blank_in;
          m_sh_blink = blink_in;
          m_pend     = 1'b1;
        end else if (wrap) begin
          m_pend = 1'b0;
        end
        n++;
      end
    end
  end

  // Monitor: compare DUT pins with the queued prediction on each falling edge.
  initial begin : monitor
    exp_t act;
    exp_t want;
    forever begin
      @(negedge CLK100MHZ);
      act = '{an: AN, a2g: A2G, dp: DP, pend: pending, fs: frame_start};
      if (!resetn) begin
        want = '{an: 8'hFF, a2g: 7'h7F, dp: 1'b1, pend: 1'b0, fs: 1'b0};
        checkOutput("reset_state", act, want);
      end else if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL scoreboard_empty @%0t: got no prediction, expected one per cycle",
                 $time);
      end else begin
        want = exp_q.pop_front();
        checkOutput("scan_output", act, want);
      end
    end
  end

  task automatic waitCycles(input int c);
    repeat (c) @(negedge CLK100MHZ);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [7:0] dpv,
                               input logic [7:0] blv, input logic [7:0] bkv);
    digit_in = d;
    dp_in    = dpv;
    blank_in = blv;
    blink_in = bkv;
    load     = 1'b1;
    waitCycles(1);
    load     = 1'b0;
  endtask

  task automatic pulseReset();
    resetn = 1'b0;
    waitCycles(3);
    resetn = 1'b1;
  endtask

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin : stimulus
    logic [31:0] rd;
    #1;
    pulseReset();
    $display("[TB] reset released, observing idle frame");
    waitCycles(FRAME + 100);

    applyStimulus(32'h1234ABCD, 8'h00, 8'h00, 8'h00);
    waitCycles(2 * FRAME);

    applyStimulus(32'h11111111, 8'h00, 8'h00, 8'h00);
    waitCycles(50);
    applyStimulus(32'h22222222, 8'h00, 8'h00, 8'h00);
    waitCycles(2 * FRAME);

    lzs_en = 1'b1;
    applyStimulus(32'h00000500, 8'h00, 8'h00, 8'h00);
    waitCycles(2 * FRAME);
    applyStimulus(32'h00000000, 8'h00, 8'h00, 8'h00);
    waitCycles(2 * FRAME);
    lzs_en = 1'b0;

    duty = 4'd3;
    waitCycles(FRAME);
    duty = 4'd0;
    waitCycles(FRAME);
    duty = 4'hF;

    applyStimulus(32'h89ABCDEF, 8'h04, 8'h80, 8'h01);
    waitCycles(5 * FRAME);

    // Load mid-frame, then load again exactly on the frame-boundary cycle.
    applyStimulus(32'h76543210, 8'h11, 8'h00, 8'h00);
    while ((n % FRAME) != FRAME - 1) waitCycles(1);
    applyStimulus(32'hFEDCBA98, 8'h22, 8'h00, 8'h00);
    waitCycles(2 * FRAME);

    // A reset while a load is pending discards the load.
    applyStimulus(32'h55555555, 8'hFF, 8'h00, 8'h00);
    waitCycles(10);
    pulseReset();
    waitCycles(FRAME + 10);

    for (int i = 0; i < 20; i++) begin
      rd     = $urandom;
      rd     = rd >> (4 * $urandom_range(0, 7));
      duty   = 4'($urandom_range(0, 15));
      lzs_en = 1'($urandom_range(0, 1));
      applyStimulus(rd, 8'($urandom), 8'($urandom) & 8'($urandom),
                    8'($urandom));
      waitCycles($urandom_range(1, FRAME));
      if ($urandom_range(0, 3) == 0) lzs_en = ~lzs_en;
      waitCycles($urandom_range(1, FRAME / 2));
    end

    waitCycles(10);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
